antares_gpr_write_ctrl: RTL and testbench

Write-port controller for the 32x32 GPR file, which has one write port, asynchronous read, hard-wired r0 and no reset. After reset it clears r1..r31 while holding the pipeline. It then shares the single write port between the pipeline writeback stage, which always has priority, and the multi-cycle multiply/divide unit (MDU), using a one-entry result buffer. It sits between the WB stage and MDU on one side and the register file's write port on the other.

---
 rtl/antares_gpr_write_ctrl_pkg.sv | 12 +
 rtl/antares_gpr_wbuf.sv | 82 ++++++++
 rtl/antares_gpr_write_ctrl.sv | 107 ++++++++++
 tb/tb_antares_gpr_write_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/antares_gpr_write_ctrl_pkg.sv
// Shared constants and state encoding for the antares GPR write-port controller.
package antares_gpr_write_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int R0_ADDR   = 0;
  localparam int GPR_COUNT = 31;

endpackage

// File: rtl/antares_gpr_wbuf.sv
// One-entry buffer for MDU results waiting for the shared GPR write port.
// Handshake: a result transfers on a cycle where mdu_req && mdu_ack; mdu_req holds wa/wd stable until then.
module antares_gpr_wbuf
  import antares_gpr_write_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int STALL_AGE  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  wb_write,
  input  logic [ADDR_WIDTH-1:0] wb_wa,
  input  logic                  mdu_req,
  input  logic [ADDR_WIDTH-1:0] mdu_wa,
  input  logic [DATA_WIDTH-1:0] mdu_wd,
  output logic                  mdu_ack,
  output logic                  drain,
  output logic                  buf_valid,
  output logic [ADDR_WIDTH-1:0] buf_wa,
  output logic [DATA_WIDTH-1:0] buf_wd,
  output logic                  stall
);

  localparam int AGE_W = (STALL_AGE < 1) ? 1 : $clog2(STALL_AGE + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STALL_AGE);

  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [AGE_W-1:0]      age_q, age_d;
  logic                  cancel;
  logic                  capture;

  always_comb begin
    drain   = run && valid_q && !wb_write;
    // A newer writeback to the same register supersedes the entry, which frees the slot.
    cancel  = wb_write && valid_q && (wb_wa == wa_q);
    mdu_ack = run && (!valid_q || drain || cancel);
    capture = mdu_req && mdu_ack;

    valid_d = valid_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    age_d   = age_q;

    if (drain || cancel) begin
      valid_d = 1'b0;
      age_d   = '0;
    end else if (valid_q && wb_write && (age_q != AGE_MAX)) begin
      age_d = age_q + AGE_W'(1);
    end

    if (capture) begin
      valid_d = (mdu_wa != ADDR_WIDTH'(R0_ADDR));
      wa_d    = mdu_wa;
      wd_d    = mdu_wd;
      age_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      age_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      age_q   <= age_d;
    end
  end

  assign buf_valid = valid_q;
  assign buf_wa    = wa_q;
  assign buf_wd    = wd_q;
  assign stall     = valid_q && (age_q >= AGE_MAX);

endmodule

// File: rtl/antares_gpr_write_ctrl.sv
// GPR write-port controller: clears r1..r31 after reset, then arbitrates the
// single write port between writeback (priority) and the buffered MDU result.
module antares_gpr_write_ctrl
  import antares_gpr_write_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int STALL_AGE  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] wb_wa,
  input  logic [DATA_WIDTH-1:0] wb_wd,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] mdu_wa,
  input  logic [DATA_WIDTH-1:0] mdu_wd,
  input  logic                  mdu_req,
  output logic                  mdu_ack,
  output logic [ADDR_WIDTH-1:0] gpr_wa,
  output logic [DATA_WIDTH-1:0] gpr_wd,
  output logic                  gpr_we,
  output logic                  init_busy,
  output logic                  wb_stall,
  output logic                  pend_valid,
  output logic [ADDR_WIDTH-1:0] pend_wa
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  run;
  logic                  wb_write;
  logic                  drain;
  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_wa;
  logic [DATA_WIDTH-1:0] buf_wd;

  assign run      = (state_q == ST_RUN);
  assign wb_write = run && wb_we && (wb_wa != ADDR_WIDTH'(R0_ADDR));

  antares_gpr_wbuf #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .STALL_AGE (STALL_AGE)
  ) u_wbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .wb_write (wb_write),
    .wb_wa    (wb_wa),
    .mdu_req  (mdu_req),
    .mdu_wa   (mdu_wa),
    .mdu_wd   (mdu_wd),
    .mdu_ack  (mdu_ack),
    .drain    (drain),
    .buf_valid(buf_valid),
    .buf_wa   (buf_wa),
    .buf_wd   (buf_wd),
    .stall    (wb_stall)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == ADDR_WIDTH'(GPR_COUNT)) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= ADDR_WIDTH'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The port is gated by rst_n directly so that it goes quiet the instant reset asserts.
  always_comb begin
    gpr_we = 1'b0;
    gpr_wa = '0;
    gpr_wd = '0;
    if (!rst_n) begin
      gpr_we = 1'b0;
    end else if (state_q == ST_INIT) begin
      gpr_we = 1'b1;
      gpr_wa = cnt_q;
    end else if (wb_write) begin
      gpr_we = 1'b1;
      gpr_wa = wb_wa;
      gpr_wd = wb_wd;
    end else if (drain) begin
      gpr_we = 1'b1;
      gpr_wa = buf_wa;
      gpr_wd = buf_wd;
    end
  end

  assign init_busy  = (state_q == ST_INIT);
  assign pend_valid = buf_valid;
  assign pend_wa    = buf_wa;

endmodule

// File: tb/tb_antares_gpr_write_ctrl.sv
// Directed bench for antares_gpr_write_ctrl: init clearing, arbitration, buffer and reset behaviour.
module tb_antares_gpr_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        wb_we;
  logic [4:0]  mdu_wa;
  logic [31:0] mdu_wd;
  logic        mdu_req;
  logic        mdu_ack;
  logic [4:0]  gpr_wa;
  logic [31:0] gpr_wd;
  logic        gpr_we;
  logic        init_busy;
  logic        wb_stall;
  logic        pend_valid;
  logic [4:0]  pend_wa;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  antares_gpr_write_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_wa     (wb_wa),
    .wb_wd     (wb_wd),
    .wb_we     (wb_we),
    .mdu_wa    (mdu_wa),
    .mdu_wd    (mdu_wd),
    .mdu_req   (mdu_req),
    .mdu_ack   (mdu_ack),
    .gpr_wa    (gpr_wa),
    .gpr_wd    (gpr_wd),
    .gpr_we    (gpr_we),
    .init_busy (init_busy),
    .wb_stall  (wb_stall),
    .pend_valid(pend_valid),
    .pend_wa   (pend_wa)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd);
    chk({tag, ".we"}, {31'd0, gpr_we}, {31'd0, we});
    chk({tag, ".wa"}, {27'd0, gpr_wa}, {27'd0, wa});
    chk({tag, ".wd"}, gpr_wd, wd);
  endtask

  // Steps through n clearing cycles starting at r1; wb writes presented here must be dropped.
  task automatic run_init(input int n);
    for (int i = 1; i <= n; i++) begin
      wb_we = (i % 8 == 0);
      wb_wa = 5'd5;
      wb_wd = 32'h5555_5555;
      #1;
      chk("init.busy", {31'd0, init_busy}, 32'd1);
      chk("init.ack", {31'd0, mdu_ack}, 32'd0);
      chk_port("init.port", 1'b1, 5'(i), 32'd0);
      @(negedge clk);
    end
    wb_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
    mdu_req = 1'b0; mdu_wa = '0; mdu_wd = '0;
    repeat (2) @(negedge clk);
    wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'hFFFF_FFFF;
    #1;
    chk_port("rst.port", 1'b0, 5'd0, 32'd0);
    chk("rst.ack", {31'd0, mdu_ack}, 32'd0);
    chk("rst.busy", {31'd0, init_busy}, 32'd1);
    chk("rst.stall", {31'd0, wb_stall}, 32'd0);
    chk("rst.pv", {31'd0, pend_valid}, 32'd0);
    chk("rst.pwa", {27'd0, pend_wa}, 32'd0);
    wb_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_init(31);

    // first RUN cycle, then MDU handshake with wb idle
    #1;
    chk("run.busy", {31'd0, init_busy}, 32'd0);
    mdu_req = 1'b1; mdu_wa = 5'd3; mdu_wd = 32'hDEAD_BEEF;
    #1;
    chk("hs.ack", {31'd0, mdu_ack}, 32'd1);
    chk_port("hs.c0", 1'b0, 5'd0, 32'd0);
    chk("hs.pv0", {31'd0, pend_valid}, 32'd0);
    @(negedge clk);
    mdu_req = 1'b0;
    #1;
    chk_port("hs.c1", 1'b1, 5'd3, 32'hDEAD_BEEF);
    chk("hs.pv1", {31'd0, pend_valid}, 32'd1);
    chk("hs.pwa1", {27'd0, pend_wa}, 32'd3);
    @(negedge clk); #1;
    chk_port("hs.c2", 1'b0, 5'd0, 32'd0);
    chk("hs.pv2", {31'd0, pend_valid}, 32'd0);

    // back-to-back acks
    @(negedge clk);
    mdu_req = 1'b1; mdu_wa = 5'd1; mdu_wd = 32'h11;
    #1;
    chk("b2b.ack0", {31'd0, mdu_ack}, 32'd1);
    @(negedge clk);
    mdu_wa = 5'd2; mdu_wd = 32'h22;
    #1;
    chk("b2b.ack1", {31'd0, mdu_ack}, 32'd1);
    chk_port("b2b.c1", 1'b1, 5'd1, 32'h11);
    @(negedge clk);
    mdu_req = 1'b0;
    #1;
    chk_port("b2b.c2", 1'b1, 5'd2, 32'h22);

    // WB priority over buffered {7, 0x1234}
    @(negedge clk);
    mdu_req = 1'b1; mdu_wa = 5'd7; mdu_wd = 32'h1234;
    wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'hA5A5_A5A5;
    #1;
    chk("pri.ack0", {31'd0, mdu_ack}, 32'd1);
    chk_port("pri.c0", 1'b1, 5'd5, 32'hA5A5_A5A5);
    @(negedge clk);
    mdu_req = 1'b0;
    #1;
    chk_port("pri.c1", 1'b1, 5'd5, 32'hA5A5_A5A5);
    chk("pri.ack1", {31'd0, mdu_ack}, 32'd0);
    chk("pri.pwa", {27'd0, pend_wa}, 32'd7);
    @(negedge clk);
    wb_we = 1'b0;
    #1;
    chk_port("pri.c2", 1'b1, 5'd7, 32'h1234);
    @(negedge clk); #1;
    chk_port("pri.c3", 1'b0, 5'd0, 32'd0);

    // wb to r0 does not block the buffer
    @(negedge clk);
    mdu_req = 1'b1; mdu_wa = 5'd12; mdu_wd = 32'hCAFE;
    #1;
    chk("r0wb.ack", {31'd0, mdu_ack}, 32'd1);
    @(negedge clk);
    mdu_req = 1'b0; wb_we = 1'b1; wb_wa = 5'd0; wb_wd = 32'hFFFF_FFFF;
    #1;
    chk_port("r0wb.c1", 1'b1, 5'd12, 32'hCAFE);
    @(negedge clk);
    wb_we = 1'b0;

    // WAW cancel of {9, 0x1111}; a new MDU result is accepted in the same cycle
    mdu_req = 1'b1; mdu_wa = 5'd9; mdu_wd = 32'h1111;
    #1;
    chk("waw.ack0", {31'd0, mdu_ack}, 32'd1);
    chk_port("waw.c0", 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    mdu_wa = 5'd10; mdu_wd = 32'h3333;
    wb_we = 1'b1; wb_wa = 5'd9; wb_wd = 32'h2222;
    #1;
    chk_port("waw.c1", 1'b1, 5'd9, 32'h2222);
    chk("waw.ack1", {31'd0, mdu_ack}, 32'd1);
    @(negedge clk);
    mdu_req = 1'b0; wb_we = 1'b0;
    #1;
    chk_port("waw.c2", 1'b1, 5'd10, 32'h3333);
    @(negedge clk); #1;
    chk_port("waw.c3", 1'b0, 5'd0, 32'd0);
    chk("waw.pv", {31'd0, pend_valid}, 32'd0);

    // starvation: wb_stall after three blocked cycles
    @(negedge clk);
    mdu_req = 1'b1; mdu_wa = 5'd6; mdu_wd = 32'h600D;
    wb_we = 1'b1; wb_wa = 5'd4; wb_wd = 32'h44;
    #1;
    chk("stv.ack", {31'd0, mdu_ack}, 32'd1);
    @(negedge clk);
    mdu_req = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      #1;
      chk("stv.stall", {31'd0, wb_stall}, (b == 4) ? 32'd1 : 32'd0);
      chk_port("stv.blk", 1'b1, 5'd4, 32'h44);
      @(negedge clk);
    end
    wb_we = 1'b0;
    #1;
    chk_port("stv.drain", 1'b1, 5'd6, 32'h600D);
    chk("stv.stall_d", {31'd0, wb_stall}, 32'd1);
    @(negedge clk); #1;
    chk("stv.stall_e", {31'd0, wb_stall}, 32'd0);
    chk("stv.pv", {31'd0, pend_valid}, 32'd0);

    // reset with a buffered result loses it immediately
    @(negedge clk);
    mdu_req = 1'b1; mdu_wa = 5'd8; mdu_wd = 32'h88;
    wb_we = 1'b1; wb_wa = 5'd4; wb_wd = 32'h44;
    @(negedge clk);
    mdu_req = 1'b0;
    #1;
    chk("mrst.pv0", {31'd0, pend_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst.pv1", {31'd0, pend_valid}, 32'd0);
    chk_port("mrst.port", 1'b0, 5'd0, 32'd0);
    chk("mrst.busy", {31'd0, init_busy}, 32'd1);
    wb_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_init(16);

    // reset pulse at counter = 17 during clearing
    #1;
    chk_port("irst.c17", 1'b1, 5'd17, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk_port("irst.drop", 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_init(31);
    #1;
    chk("irst.busy", {31'd0, init_busy}, 32'd0);
    chk_port("irst.idle", 1'b0, 5'd0, 32'd0);

    // MDU result to r0 is acked and discarded
    mdu_req = 1'b1; mdu_wa = 5'd0; mdu_wd = 32'hBAD0_BAD0;
    #1;
    chk("r0mdu.ack", {31'd0, mdu_ack}, 32'd1);
    chk_port("r0mdu.c0", 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    mdu_req = 1'b0;
    #1;
    chk_port("r0mdu.c1", 1'b0, 5'd0, 32'd0);
    chk("r0mdu.pv", {31'd0, pend_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

endmodule
